// File: rtl/simon_stream_master_if.sv
// Signal bundle between a streaming client, the Simon stream master and the
// Simon 32/64 peripheral register port.
interface simon_stream_master_if;
   logic [63:0] key;
   logic        key_load;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        s_mode;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        busy;
   logic [7:0]  bus_address;
   logic [31:0] bus_wdata;
   logic        bus_wen;
   logic        bus_ren;
   logic [31:0] bus_rdata;

   modport master (
      input  key, key_load, s_valid, s_data, s_mode, m_ready, bus_rdata,
      output s_ready, m_valid, m_data, busy, bus_address, bus_wdata, bus_wen, bus_ren
   );

   modport slave (
      output key, key_load, s_valid, s_data, s_mode, m_ready, bus_rdata,
      input  s_ready, m_valid, m_data, busy, bus_address, bus_wdata, bus_wen, bus_ren
   );
endinterface

// File: rtl/simon_stream_master.sv
// Bus initiator that feeds stream words through the Simon 32/64 peripheral:
// optional key load, data write, fixed-latency wait, result read, stream out.
module simon_stream_master #(
   parameter int CORE_LATENCY = 34
) (
   input logic                    i_clk,
   input logic                    i_reset,
   simon_stream_master_if.master  io_port
);

   typedef enum logic [2:0] {
      IDLE, KEY_LO, KEY_HI, WRITE, WAIT, READ, CAPTURE, OUTPUT
   } state_t;

   localparam logic [7:0] LAT_M1 = 8'(CORE_LATENCY - 1);

   state_t      r_state;
   state_t      w_nextState;
   logic [63:0] r_keyReg;
   logic        r_keyPend;
   logic        r_keyLoaded;
   logic [31:0] r_data;
   logic        r_mode;
   logic [7:0]  r_count;
   logic [31:0] r_mData;

   logic        w_sReady;
   logic        w_accept;
   logic        w_busWen;
   logic        w_busRen;
   logic [7:0]  w_busAddress;
   logic [31:0] w_busWdata;

   // A pending or incoming key load always blocks new words until the reload is done.
   always_comb begin
      w_sReady     = (r_state == IDLE) && r_keyLoaded && !r_keyPend && !io_port.key_load;
      w_accept     = w_sReady && io_port.s_valid;
      w_nextState  = r_state;
      w_busWen     = 1'b0;
      w_busRen     = 1'b0;
      w_busAddress = 8'd0;
      w_busWdata   = 32'd0;
      case (r_state)
         IDLE: begin
            if (r_keyPend || io_port.key_load) w_nextState = KEY_LO;
            else if (w_accept)                 w_nextState = WRITE;
         end
         KEY_LO: begin
            w_busWen     = 1'b1;
            w_busAddress = 8'd0;
            w_busWdata   = r_keyReg[31:0];
            w_nextState  = KEY_HI;
         end
         KEY_HI: begin
            w_busWen     = 1'b1;
            w_busAddress = 8'd1;
            w_busWdata   = r_keyReg[63:32];
            w_nextState  = IDLE;
         end
         WRITE: begin
            w_busWen     = 1'b1;
            w_busAddress = r_mode ? 8'd3 : 8'd2;
            w_busWdata   = r_data;
            w_nextState  = WAIT;
         end
         WAIT: begin
            if (r_count == 8'd0) w_nextState = READ;
         end
         READ: begin
            w_busRen     = 1'b1;
            w_busAddress = r_mode ? 8'd5 : 8'd4;
            w_nextState  = CAPTURE;
         end
         CAPTURE: w_nextState = OUTPUT;
         OUTPUT: begin
            if (io_port.m_ready) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // The counter starts at latency-1 so that WAIT spans exactly CORE_LATENCY cycles.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_keyReg    <= 64'd0;
         r_keyPend   <= 1'b0;
         r_keyLoaded <= 1'b0;
         r_data      <= 32'd0;
         r_mode      <= 1'b0;
         r_count     <= 8'd0;
         r_mData     <= 32'd0;
      end else begin
         r_state <= w_nextState;
         if (io_port.key_load) begin
            r_keyReg  <= io_port.key;
            r_keyPend <= 1'b1;
         end else if (r_state == KEY_HI) begin
            r_keyPend <= 1'b0;
         end
         if (r_state == KEY_HI) r_keyLoaded <= 1'b1;
         if (w_accept) begin
            r_data <= io_port.s_data;
            r_mode <= io_port.s_mode;
         end
         if (r_state == WRITE)     r_count <= LAT_M1;
         else if (r_state == WAIT) r_count <= r_count - 8'd1;
         if (r_state == CAPTURE) r_mData <= io_port.bus_rdata;
      end
   end

   assign io_port.s_ready     = w_sReady;
   assign io_port.m_valid     = (r_state == OUTPUT);
   assign io_port.m_data      = r_mData;
   assign io_port.busy        = (r_state != IDLE) || r_keyPend;
   assign io_port.bus_wen     = w_busWen;
   assign io_port.bus_ren     = w_busRen;
   assign io_port.bus_address = w_busAddress;
   assign io_port.bus_wdata   = w_busWdata;

endmodule
